// File: rtl/em_result_buffer.sv
// Result buffer behind the 8-sensor EM block: acknowledges each EM result, tags it with a
// sequence number and queues it in a first-word-fall-through FIFO for the CPU.
module em_result_buffer #(
  parameter int DEPTH          = 8,
  parameter bit DROP_WHEN_FULL = 1'b0,
  parameter int DATA_W         = 16,
  parameter int TAG_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        em_result,
  input  logic                     em_val_ready,
  output logic                     cpu_read_complete,
  input  logic                     rd_pop,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [TAG_W-1:0]   tag_q;
  logic               overflow_q;
  logic               accept, wr_en, drop, pop;

  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [TAG_W-1:0]   tag_mem  [DEPTH];

  assign full     = (count_q == FULL_CNT);
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;

  // Capture FSM: one accept, one ack cycle, one gap cycle while the EM output updates
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && em_val_ready && (!full || DROP_WHEN_FULL)) begin
          accept  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  assign cpu_read_complete = (state_q == S_ACK);

  // Full is taken from the registered count, so a same-cycle pop never makes room
  assign wr_en = accept && !full;
  assign drop  = accept && full;
  assign pop   = enable && rd_pop && rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
    end else if (!enable) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
      // Tag advances on discarded samples too, so the CPU sees loss as a tag gap
      if (accept) tag_q <= tag_q + 1'b1;
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  // Storage is data only; validity comes from count_q
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr] <= em_result;
      tag_mem[wr_ptr]  <= tag_q;
    end
  end

  assign rd_data = rd_valid ? data_mem[rd_ptr] : '0;
  assign rd_tag  = rd_valid ? tag_mem[rd_ptr]  : '0;

endmodule

// File: tb/tb_em_result_buffer.sv
// Bench for em_result_buffer: stall-mode and drop-mode instances share stimulus and are
// checked every cycle against a queue-level model plus directed literal expectations.
module tb_em_result_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] em_result = '0;
  logic        em_val_ready = 1'b0;
  logic        rd_pop = 1'b0;
  logic        overflow_clr = 1'b0;

  logic        crc0, rv0, fl0, ov0, crc1, rv1, fl1, ov1;
  logic [15:0] rd0, rd1;
  logic [7:0]  rt0, rt1;
  logic [3:0]  cnt0, cnt1;

  int n_checks = 0;
  int n_pass   = 0;
  int acks;

  always #5 clk = ~clk;

  em_result_buffer #(.DEPTH(DEPTH), .DROP_WHEN_FULL(1'b0)) u_stall (
    .clk(clk), .rst_n(rst_n), .enable(enable), .em_result(em_result),
    .em_val_ready(em_val_ready), .cpu_read_complete(crc0), .rd_pop(rd_pop),
    .rd_valid(rv0), .rd_data(rd0), .rd_tag(rt0), .count(cnt0), .full(fl0),
    .overflow(ov0), .overflow_clr(overflow_clr)
  );

  em_result_buffer #(.DEPTH(DEPTH), .DROP_WHEN_FULL(1'b1)) u_drop (
    .clk(clk), .rst_n(rst_n), .enable(enable), .em_result(em_result),
    .em_val_ready(em_val_ready), .cpu_read_complete(crc1), .rd_pop(rd_pop),
    .rd_valid(rv1), .rd_data(rd1), .rd_tag(rt1), .count(cnt1), .full(fl1),
    .overflow(ov1), .overflow_clr(overflow_clr)
  );

  // Model: per instance, an ordered list of {data, tag} with head at index 0
  logic [23:0] mlist [2][DEPTH];
  int          msize [2] = '{0, 0};
  logic [7:0]  mtag  [2] = '{8'd0, 8'd0};
  int          mph   [2] = '{0, 0};   // 0 waiting, 1 ack cycle, 2 gap cycle
  logic        movf  [2] = '{1'b0, 1'b0};
  logic        m_full, m_pop, m_acc;

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || !enable) begin
        msize[d] = 0; mtag[d] = 8'd0; mph[d] = 0; movf[d] = 1'b0;
      end else begin
        m_full = (msize[d] == DEPTH);
        m_pop  = rd_pop && (msize[d] > 0);
        m_acc  = (mph[d] == 0) && em_val_ready && (!m_full || d == 1);
        if (m_pop) begin
          for (int i = 0; i < DEPTH - 1; i++) mlist[d][i] = mlist[d][i+1];
          msize[d] = msize[d] - 1;
        end
        if (m_acc && !m_full) begin
          mlist[d][msize[d]] = {em_result, mtag[d]};
          msize[d] = msize[d] + 1;
        end
        if (m_acc && m_full)   movf[d] = 1'b1;
        else if (overflow_clr) movf[d] = 1'b0;
        if (m_acc) mtag[d] = mtag[d] + 8'd1;
        if (m_acc)             mph[d] = 1;
        else if (mph[d] == 1)  mph[d] = 2;
        else                   mph[d] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  task automatic cmp(input int d, input logic a_crc, input logic a_rv, input logic [15:0] a_rd,
                     input logic [7:0] a_rt, input logic [3:0] a_cnt, input logic a_fl,
                     input logic a_ov);
    logic [23:0] head;
    head = (msize[d] > 0) ? mlist[d][0] : 24'd0;
    chk($sformatf("u%0d.cpu_read_complete", d), 32'(a_crc), 32'(mph[d] == 1));
    chk($sformatf("u%0d.rd_valid", d), 32'(a_rv), 32'(msize[d] > 0));
    chk($sformatf("u%0d.rd_data", d), 32'(a_rd), 32'(head[23:8]));
    chk($sformatf("u%0d.rd_tag", d), 32'(a_rt), 32'(head[7:0]));
    chk($sformatf("u%0d.count", d), 32'(a_cnt), 32'(msize[d]));
    chk($sformatf("u%0d.full", d), 32'(a_fl), 32'(msize[d] == DEPTH));
    chk($sformatf("u%0d.overflow", d), 32'(a_ov), 32'(movf[d]));
  endtask

  initial forever begin
    @(negedge clk);
    cmp(0, crc0, rv0, rd0, rt0, cnt0, fl0, ov0);
    cmp(1, crc1, rv1, rd1, rt1, cnt1, fl1, ov1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    enable = 1'b0;
    cyc();
    enable = 1'b1;
  endtask

  task automatic slow_write(input logic [15:0] v);
    em_result = v;
    em_val_ready = 1'b1;
    cyc();
    em_val_ready = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic zero_chk(input string nm);
    chk({nm, ".stall_outputs"}, {11'd0, crc0, rv0, rd0, rt0, cnt0, fl0, ov0}, 32'd0);
    chk({nm, ".drop_outputs"},  {11'd0, crc1, rv1, rd1, rt1, cnt1, fl1, ov1}, 32'd0);
  endtask

  initial begin
    // Reset with random inputs
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      em_result    = 16'($urandom);
      em_val_ready = 1'($urandom);
      rd_pop       = 1'($urandom);
      overflow_clr = 1'($urandom);
      enable       = 1'($urandom);
      cyc();
      zero_chk("reset_random");
    end
    em_result = '0; em_val_ready = 1'b0; rd_pop = 1'b0; overflow_clr = 1'b0; enable = 1'b1;
    cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    zero_chk("post_reset_idle");

    // Slow-mode single sample
    em_result = 16'h00A5; em_val_ready = 1'b1;
    cyc();
    em_val_ready = 1'b0;
    chk("single.ack", 32'(crc0), 32'd1);
    chk("single.rd_valid", 32'(rv0), 32'd1);
    chk("single.rd_data", 32'(rd0), 32'h00A5);
    chk("single.rd_tag", 32'(rt0), 32'd0);
    chk("single.count", 32'(cnt0), 32'd1);
    cyc();
    chk("single.ack_one_cycle", 32'(crc0), 32'd0);
    rd_pop = 1'b1;
    cyc();
    rd_pop = 1'b0;
    chk("single.pop_valid", 32'(rv0), 32'd0);
    chk("single.pop_count", 32'(cnt0), 32'd0);

    // Stall mode fill with em_val_ready held high
    flush();
    acks = 0;
    em_val_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      em_result = {8'h00, 8'(i)};
      cyc();
      if (crc0) acks++;
    end
    chk("fill.acks", 32'(acks), 32'd8);
    chk("fill.full", 32'(fl0), 32'd1);
    chk("fill.head_tag", 32'(rt0), 32'd0);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (crc0) acks++;
    end
    chk("stall.no_ack", 32'(acks), 32'd0);
    chk("stall.overflow", 32'(ov0), 32'd0);
    rd_pop = 1'b1;
    cyc();
    rd_pop = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (crc0) acks++;
    end
    chk("stall.one_more_ack", 32'(acks), 32'd1);
    chk("stall.refill_count", 32'(cnt0), 32'd8);
    em_val_ready = 1'b0;
    rd_pop = 1'b1;
    repeat (7) cyc();
    rd_pop = 1'b0;
    chk("stall.tail_tag", 32'(rt0), 32'd8);
    chk("stall.tail_count", 32'(cnt0), 32'd1);

    // Drop mode: ten accepts into an eight-deep FIFO
    flush();
    acks = 0;
    em_val_ready = 1'b1;
    for (int i = 0; i < 40 && acks < 10; i++) begin
      em_result = {8'h00, 8'(8'h40 + i)};
      cyc();
      if (crc1) begin
        acks++;
        if (acks == 8) chk("drop.ovf_before", 32'(ov1), 32'd0);
        if (acks == 9) chk("drop.ovf_after9", 32'(ov1), 32'd1);
      end
    end
    em_val_ready = 1'b0;
    chk("drop.acks", 32'(acks), 32'd10);
    chk("drop.count", 32'(cnt1), 32'd8);
    rd_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drop.drain_tag", 32'(rt1), 32'(i));
      cyc();
    end
    rd_pop = 1'b0;
    chk("drop.drained", 32'(cnt1), 32'd0);
    em_result = 16'h005A; em_val_ready = 1'b1;
    cyc();
    em_val_ready = 1'b0;
    chk("drop.next_tag", 32'(rt1), 32'd10);
    chk("drop.next_data", 32'(rd1), 32'h005A);
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    chk("drop.ovf_clr", 32'(ov1), 32'd0);
    cyc();

    // Simultaneous write and pop
    flush();
    slow_write(16'h0001);
    slow_write(16'h0002);
    slow_write(16'h0003);
    chk("simul.pre_count", 32'(cnt0), 32'd3);
    em_result = 16'h0033; em_val_ready = 1'b1; rd_pop = 1'b1;
    cyc();
    em_val_ready = 1'b0; rd_pop = 1'b0;
    chk("simul.count", 32'(cnt0), 32'd3);
    chk("simul.head_tag", 32'(rt0), 32'd1);
    cyc();
    cyc();
    rd_pop = 1'b1;
    repeat (3) cyc();
    chk("simul.emptied", 32'(cnt0), 32'd0);
    cyc();
    rd_pop = 1'b0;
    chk("underflow.count", 32'(cnt0), 32'd0);
    chk("underflow.valid", 32'(rv0), 32'd0);
    slow_write(16'h0011);
    chk("one.tag", 32'(rt0), 32'd4);
    em_result = 16'h0077; em_val_ready = 1'b1; rd_pop = 1'b1;
    cyc();
    em_val_ready = 1'b0; rd_pop = 1'b0;
    chk("one.count", 32'(cnt0), 32'd1);
    chk("one.new_head", 32'(rd0), 32'h0077);
    chk("one.new_tag", 32'(rt0), 32'd5);
    cyc();
    cyc();

    // Enable drop during ack, then asynchronous resets
    flush();
    for (int i = 0; i < 4; i++) slow_write(16'(16'h0020 + i));
    em_result = 16'h0024; em_val_ready = 1'b1;
    cyc();
    em_val_ready = 1'b0;
    chk("disable.ack", 32'(crc0), 32'd1);
    chk("disable.count5", 32'(cnt0), 32'd5);
    enable = 1'b0;
    cyc();
    chk("disable.count", 32'(cnt0), 32'd0);
    chk("disable.ack_off", 32'(crc0), 32'd0);
    chk("disable.valid", 32'(rv0), 32'd0);
    enable = 1'b1;
    em_result = 16'h00E1; em_val_ready = 1'b1;
    cyc();
    em_val_ready = 1'b0;
    chk("reenable.tag", 32'(rt0), 32'd0);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    zero_chk("reset_gap");
    @(posedge clk);
    #1 rst_n = 1'b1;
    em_result = 16'h00E2; em_val_ready = 1'b1;
    cyc();
    em_val_ready = 1'b0;
    chk("reset_ack.pre", 32'(crc0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    zero_chk("reset_ack");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("reset_ack.lost", 32'(cnt0), 32'd0);

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
